// File: rtl/mult_div_seq_if.sv
// Operand/result bus between the register file side and the multiply/divide unit.
interface mult_div_seq_if #(
    parameter int unsigned LARGURA = 32
);
    logic               inicio;
    logic [1:0]         operacao;
    logic [LARGURA-1:0] op1;
    logic [LARGURA-1:0] op2;
    logic               ocupado;
    logic               pronto;
    logic               div_zero;
    logic [LARGURA-1:0] hi;
    logic [LARGURA-1:0] lo;

    modport master (
        output inicio, operacao, op1, op2,
        input  ocupado, pronto, div_zero, hi, lo
    );

    modport slave (
        input  inicio, operacao, op1, op2,
        output ocupado, pronto, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_seq.sv
// Multi-cycle signed/unsigned multiply and divide with Hi/Lo result registers.
// One shift-and-add or restoring-division step per cycle, sign fix-up at the end.
module mult_div_seq #(
    parameter int unsigned LARGURA = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    mult_div_seq_if.slave bus
);
    localparam int unsigned L  = LARGURA;
    localparam int unsigned AW = 2 * LARGURA;
    localparam int unsigned CW = $clog2(LARGURA);
    localparam logic [CW-1:0] ULTIMA = CW'(LARGURA - 1);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] AJUSTE = 2'd2;
    localparam logic [1:0] FIM    = 2'd3;

    logic [1:0]    estado, estado_nxt;
    logic          div_q, div_nxt;
    logic [L-1:0]  mag, mag_nxt;
    logic [AW-1:0] acc, acc_nxt;
    logic [CW-1:0] cont, cont_nxt;
    logic          neg_a, neg_a_nxt;
    logic          neg_r, neg_r_nxt;
    logic [L-1:0]  hi_q, hi_nxt;
    logic [L-1:0]  lo_q, lo_nxt;
    logic          dz_q, dz_nxt;
    logic          ocupado_q, ocupado_nxt;
    logic          pronto_q, pronto_nxt;

    // Operand magnitudes and signs; signed ops have operacao[0] = 0
    logic         s1, s2, is_div, por_zero, aceita;
    logic [L-1:0] abs1, abs2;
    assign s1       = ~bus.operacao[0] & bus.op1[L-1];
    assign s2       = ~bus.operacao[0] & bus.op2[L-1];
    assign abs1     = s1 ? (~bus.op1 + L'(1)) : bus.op1;
    assign abs2     = s2 ? (~bus.op2 + L'(1)) : bus.op2;
    assign is_div   = bus.operacao[1];
    assign por_zero = is_div & (bus.op2 == {L{1'b0}});
    assign aceita   = bus.inicio & ((estado == OCIOSO) || (estado == FIM));

    // Single iteration of each algorithm over the shared accumulator
    logic [L:0]    soma, dif;
    logic [AW-1:0] passo_mul, passo_div;
    logic [AW-1:0] prod_fin;
    logic [L-1:0]  quo_fin, rem_fin;
    assign soma      = {1'b0, acc[AW-1:L]} + (acc[0] ? {1'b0, mag} : {(L+1){1'b0}});
    assign passo_mul = {soma, acc[L-1:1]};
    assign dif       = acc[AW-1:L-1] - {1'b0, mag};
    assign passo_div = dif[L] ? {acc[AW-2:0], 1'b0} : {dif[L-1:0], acc[L-2:0], 1'b1};
    assign prod_fin  = neg_a ? (~acc + AW'(1)) : acc;
    assign quo_fin   = neg_a ? (~acc[L-1:0] + L'(1)) : acc[L-1:0];
    assign rem_fin   = neg_r ? (~acc[AW-1:L] + L'(1)) : acc[AW-1:L];

    always_comb begin
        estado_nxt = estado;
        div_nxt    = div_q;
        mag_nxt    = mag;
        acc_nxt    = acc;
        cont_nxt   = cont;
        neg_a_nxt  = neg_a;
        neg_r_nxt  = neg_r;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        dz_nxt     = dz_q;
        case (estado)
            CALC: begin
                acc_nxt  = div_q ? passo_div : passo_mul;
                cont_nxt = cont + CW'(1);
                if (cont == ULTIMA) estado_nxt = AJUSTE;
            end
            AJUSTE: begin
                if (div_q) begin
                    hi_nxt = rem_fin;
                    lo_nxt = quo_fin;
                end else begin
                    hi_nxt = prod_fin[AW-1:L];
                    lo_nxt = prod_fin[L-1:0];
                end
                estado_nxt = FIM;
            end
            default: begin
                if (estado == FIM) estado_nxt = OCIOSO;
                if (aceita) begin
                    div_nxt   = is_div;
                    dz_nxt    = 1'b0;
                    cont_nxt  = {CW{1'b0}};
                    neg_a_nxt = s1 ^ s2;
                    neg_r_nxt = s1;
                    mag_nxt   = is_div ? abs2 : abs1;
                    acc_nxt   = {{L{1'b0}}, (is_div ? abs1 : abs2)};
                    if (por_zero) begin
                        hi_nxt     = bus.op1;
                        lo_nxt     = {L{1'b1}};
                        dz_nxt     = 1'b1;
                        estado_nxt = FIM;
                    end else begin
                        estado_nxt = CALC;
                    end
                end
            end
        endcase
        ocupado_nxt = (estado_nxt == CALC) || (estado_nxt == AJUSTE);
        pronto_nxt  = (estado_nxt == FIM);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= OCIOSO;
            div_q     <= 1'b0;
            mag       <= {L{1'b0}};
            acc       <= {AW{1'b0}};
            cont      <= {CW{1'b0}};
            neg_a     <= 1'b0;
            neg_r     <= 1'b0;
            hi_q      <= {L{1'b0}};
            lo_q      <= {L{1'b0}};
            dz_q      <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado    <= estado_nxt;
            div_q     <= div_nxt;
            mag       <= mag_nxt;
            acc       <= acc_nxt;
            cont      <= cont_nxt;
            neg_a     <= neg_a_nxt;
            neg_r     <= neg_r_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
            dz_q      <= dz_nxt;
            ocupado_q <= ocupado_nxt;
            pronto_q  <= pronto_nxt;
        end
    end

    assign bus.ocupado  = ocupado_q;
    assign bus.pronto   = pronto_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: arithmetic reference model plus a
// cycle-level expectation of ocupado/pronto/hi/lo/div_zero compared every cycle.
module tb_mult_div_seq;
    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    mult_div_seq_if #(.LARGURA(32)) bus ();

    mult_div_seq #(.LARGURA(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference arithmetic: returns {div_zero, hi, lo}
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, p, q, m;
        logic [63:0] up;
        logic [31:0] uq, um;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ref_op = '0;
        case (op)
            2'b00: begin
                p = sa * sb;
                ref_op = {1'b0, 64'(p)};
            end
            2'b01: begin
                up = 64'(a) * 64'(b);
                ref_op = {1'b0, up};
            end
            2'b10: begin
                if (b == 32'd0) ref_op = {1'b1, a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    ref_op = {1'b0, m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) ref_op = {1'b1, a, 32'hFFFFFFFF};
                else begin
                    uq = a / b;
                    um = a % b;
                    ref_op = {1'b0, um, uq};
                end
            end
        endcase
    endfunction

    // Expected output view: a countdown of remaining busy cycles
    int          rem_cyc = 0;
    logic [31:0] e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
    logic        e_dz = 1'b0, e_pronto = 1'b0;
    logic [64:0] r_acc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_cyc = 0; e_hi = '0; e_lo = '0; e_dz = 1'b0; e_pronto = 1'b0;
        end else begin
            e_pronto = 1'b0;
            if (rem_cyc > 0) begin
                rem_cyc--;
                if (rem_cyc == 0) begin
                    e_hi = p_hi; e_lo = p_lo; e_pronto = 1'b1;
                end
            end else if (bus.inicio === 1'b1) begin
                r_acc = ref_op(bus.operacao, bus.op1, bus.op2);
                e_dz  = r_acc[64];
                if (r_acc[64]) begin
                    e_hi = r_acc[63:32]; e_lo = r_acc[31:0]; e_pronto = 1'b1;
                end else begin
                    p_hi = r_acc[63:32]; p_lo = r_acc[31:0]; rem_cyc = 33;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("cyc_ocupado",  64'(bus.ocupado),  64'(rem_cyc > 0));
        chk("cyc_pronto",   64'(bus.pronto),   64'(e_pronto));
        chk("cyc_div_zero", 64'(bus.div_zero), 64'(e_dz));
        chk("cyc_hi",       64'(bus.hi),       64'(e_hi));
        chk("cyc_lo",       64'(bus.lo),       64'(e_lo));
    end

    task automatic start_now(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.inicio = 1'b1; bus.operacao = op; bus.op1 = a; bus.op2 = b;
        @(negedge clock);
        bus.inicio = 1'b0; bus.operacao = 2'($urandom); bus.op1 = $urandom; bus.op2 = $urandom;
    endtask

    // Waits (bounded) for pronto; n is the cycle number counted from the start edge
    task automatic wait_pronto(input int noise_at, input bit rnd, output int n);
        n = 1;
        while (bus.pronto !== 1'b1 && n < 100) begin
            if (n == noise_at || (rnd && n >= 2 && n < 30 && ($urandom % 4 == 0))) begin
                bus.inicio = 1'b1; bus.operacao = 2'($urandom);
                bus.op1 = $urandom; bus.op2 = $urandom;
            end else bus.inicio = 1'b0;
            @(negedge clock);
            n++;
        end
        bus.inicio = 1'b0;
    endtask

    task automatic run(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int noise_at, input bit rnd,
                       output logic [63:0] res);
        logic [64:0] r;
        int n;
        r = ref_op(op, a, b);
        start_now(op, a, b);
        wait_pronto(noise_at, rnd, n);
        chk({nm, "_lat"}, 64'(n), r[64] ? 64'd1 : 64'd34);
        chk({nm, "_hilo"}, {bus.hi, bus.lo}, r[63:0]);
        chk({nm, "_dz"}, 64'(bus.div_zero), 64'(r[64]));
        res = {bus.hi, bus.lo};
        @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom % 8)
            0: v = 32'h0;
            1: v = 32'hFFFFFFFF;
            2: v = 32'h80000000;
            3: v = 32'h1;
            4: v = 32'($urandom % 16);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] res;
        logic [64:0] mr;
        int n;
        reset_n = 1'b0;
        bus.inicio = 1'b0; bus.operacao = 2'b00; bus.op1 = '0; bus.op2 = '0;
        repeat (3) @(negedge clock);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_ocupado", 64'(bus.ocupado), 64'd0);
        chk("rst_pronto", 64'(bus.pronto), 64'd0);
        chk("rst_dz", 64'(bus.div_zero), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Pin the reference model with hand-computed results
        mr = ref_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        chk("model_ovf", mr[63:0], 64'h00000000_80000000);
        mr = ref_op(2'b11, 32'd100, 32'd0);
        chk("model_dz", 64'(mr), {32'd100, 32'hFFFFFFFF});

        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, res);
        chk("multu_max_lit", res, 64'hFFFFFFFE_00000001);
        run("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, -1, 1'b0, res);
        chk("mult_m3x7_lit", res, 64'hFFFFFFFF_FFFFFFEB);
        run("mult_min2", 2'b00, 32'h80000000, 32'h80000000, -1, 1'b0, res);
        chk("mult_min2_lit", res, 64'h40000000_00000000);
        run("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, -1, 1'b0, res);
        chk("div_m7d2_lit", res, 64'hFFFFFFFF_FFFFFFFD);
        run("divu_100d7", 2'b11, 32'd100, 32'd7, -1, 1'b0, res);
        chk("divu_100d7_lit", res, {32'd2, 32'd14});
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, res);
        chk("div_ovf_lit", res, 64'h00000000_80000000);
        run("divu_5d0", 2'b11, 32'd5, 32'd0, -1, 1'b0, res);
        chk("divu_5d0_lit", res, {32'd5, 32'hFFFFFFFF});

        // A following mult clears div_zero at its start edge
        start_now(2'b00, 32'd3, 32'd4);
        chk("dz_clear", 64'(bus.div_zero), 64'd0);
        chk("dz_clear_busy", 64'(bus.ocupado), 64'd1);
        wait_pronto(-1, 1'b0, n);
        chk("mult_3x4_lit", {bus.hi, bus.lo}, 64'd12);
        @(negedge clock);

        // Start while busy is ignored
        run("busy_ign", 2'b11, 32'd1000, 32'd9, 10, 1'b0, res);
        chk("busy_ign_lit", res, {32'd1, 32'd111});

        // Back-to-back: inicio during the pronto cycle
        start_now(2'b01, 32'd6, 32'd7);
        wait_pronto(-1, 1'b0, n);
        chk("b2b_first", {bus.hi, bus.lo}, 64'd42);
        start_now(2'b10, 32'd20, 32'hFFFFFFFD);
        chk("b2b_busy", 64'(bus.ocupado), 64'd1);
        wait_pronto(-1, 1'b0, n);
        chk("b2b_lat", 64'(n), 64'd34);
        chk("b2b_res", {bus.hi, bus.lo}, {32'd2, 32'hFFFFFFFA});
        @(negedge clock);

        // Reset mid-operation aborts at once
        start_now(2'b10, 32'hFFFFFF9C, 32'd7);
        repeat (14) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        chk("midrst_ocupado", 64'(bus.ocupado), 64'd0);
        chk("midrst_pronto", 64'(bus.pronto), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("midrst_idle", 64'({bus.ocupado, bus.pronto}), 64'd0);

        // Randomized operations with busy-time noise on inicio
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom);
            run("rnd", op, pick(), pick(), -1, 1'b1, res);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
